// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory responder.
// Holds the scrub FSM state type, default addresses and byte-lane merge.
package mips_mem_pkg;

    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } mem_state_t;

    localparam logic [31:0] DEF_DATA_BASE    = 32'h1000_0000;
    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'hFFFF_0000;
    localparam int          DEF_DATA_WORDS   = 1024;

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  mask
    );
        logic [31:0] w;
        w = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                w[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mips_mem_scrub.sv
// Post-reset scrub sequencer: walks every word index once, then idles.
// init_busy stays high for exactly DATA_WORDS cycles after reset release.
module mips_mem_scrub
    import mips_mem_pkg::*;
#(
    parameter int DATA_WORDS = DEF_DATA_WORDS,
    parameter int IDX_W      = $clog2(DATA_WORDS)
) (
    input  logic             clk,
    input  logic             rst_b,
    output logic             init_busy,
    output logic             scrub_we,
    output logic [IDX_W-1:0] scrub_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WORDS - 1);

    mem_state_t       state_q;
    mem_state_t       state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // state and scrub index registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= SCRUB;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // next state, index advance and scrub write strobe
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        scrub_we  = 1'b0;
        init_busy = 1'b0;
        unique case (state_q)
            SCRUB: begin
                scrub_we  = 1'b1;
                init_busy = 1'b1;
                idx_d     = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
        endcase
    end

    assign scrub_idx = idx_q;

endmodule

// File: rtl/mips_data_mem.sv
// Data memory for the single-cycle MIPS core: async read, byte-lane write.
// Optional console register at CONSOLE_ADDR when MMIO_CONSOLE_EN is defined.
module mips_data_mem
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] DATA_BASE    = DEF_DATA_BASE,
    parameter int          DATA_WORDS   = DEF_DATA_WORDS,
    parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [29:0] mem_addr,
    input  logic [31:0] mem_data_in,
    input  logic [3:0]  mem_write_en,
    input  logic        mem_rd_en,
    output logic [31:0] mem_data_out,
    output logic        mem_excpt,
    output logic        init_busy,
    output logic        err_valid,
    output logic [29:0] err_addr
`ifdef MMIO_CONSOLE_EN
    ,
    output logic        console_valid,
    output logic [7:0]  console_char
`endif
);

    localparam int          IDX_W  = $clog2(DATA_WORDS);
    localparam logic [29:0] BASE_W = DATA_BASE[31:2];
    localparam logic [29:0] SIZE_W = 30'(DATA_WORDS);
    localparam logic [29:0] CONS_W = CONSOLE_ADDR[31:2];

    logic [31:0]      mem_array [DATA_WORDS];

    logic             scrub_we;
    logic [IDX_W-1:0] scrub_idx;
    logic             ready;

    logic [29:0]      addr_diff;
    logic             in_range;
    logic [IDX_W-1:0] offset;
    logic             addr_ok;
    logic             core_req;
    logic [31:0]      rd_word;

    logic             arr_we;
    logic [IDX_W-1:0] arr_idx;
    logic [31:0]      arr_wdata;

    mips_mem_scrub #(
        .DATA_WORDS (DATA_WORDS),
        .IDX_W      (IDX_W)
    ) u_scrub (
        .clk       (clk),
        .rst_b     (rst_b),
        .init_busy (init_busy),
        .scrub_we  (scrub_we),
        .scrub_idx (scrub_idx)
    );

    assign ready = !init_busy;

    // Addresses below the base wrap high in 30 bits and fail the compare.
    assign addr_diff = mem_addr - BASE_W;
    assign in_range  = addr_diff < SIZE_W;
    assign offset    = addr_diff[IDX_W-1:0];
    assign core_req  = mem_rd_en || (|mem_write_en);
    assign rd_word   = mem_array[offset];

`ifdef MMIO_CONSOLE_EN
    logic cons_hit;
    assign cons_hit = (mem_addr == CONS_W) && !in_range;
    assign addr_ok  = in_range || cons_hit;
`else
    logic unused_cons_hit;
    assign unused_cons_hit = (mem_addr == CONS_W);
    assign addr_ok         = in_range;
`endif

    assign mem_excpt    = ready && !addr_ok && core_req;
    assign mem_data_out = (ready && in_range) ? rd_word : 32'h0;

    // single write port shared by the scrubber and core stores
    always_comb begin
        arr_we    = 1'b0;
        arr_idx   = offset;
        arr_wdata = lane_merge(rd_word, mem_data_in, mem_write_en);
        if (scrub_we) begin
            arr_we    = 1'b1;
            arr_idx   = scrub_idx;
            arr_wdata = 32'h0;
        end else if (ready && in_range && (|mem_write_en)) begin
            arr_we = 1'b1;
        end
    end

    // storage array, cleared by the scrub rather than by reset
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem_array[arr_idx] <= arr_wdata;
        end
    end

    // capture the first faulting word address until the next reset
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (mem_excpt && !err_valid) begin
            err_valid <= 1'b1;
            err_addr  <= mem_addr;
        end
    end

`ifdef MMIO_CONSOLE_EN
    // console register: one-cycle strobe per lane-0 write
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            console_valid <= 1'b0;
            console_char  <= 8'h0;
        end else begin
            console_valid <= ready && cons_hit && mem_write_en[0];
            if (ready && cons_hit && mem_write_en[0]) begin
                console_char <= mem_data_in[7:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_data_mem.sv
// Self-checking bench for mips_data_mem with a 16-word array.
// Byte-addressed reference model plus directed literal checks.
module tb_mips_data_mem;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          WORDS = 16;
    localparam logic [31:0] CONS  = 32'hFFFF_0000;
    localparam logic [29:0] BW    = 30'h0400_0000;
    localparam logic [29:0] CW    = 30'h3FFF_C000;

    logic        clk          = 1'b0;
    logic        rst_b        = 1'b0;
    logic [29:0] mem_addr     = '0;
    logic [31:0] mem_data_in  = '0;
    logic [3:0]  mem_write_en = '0;
    logic        mem_rd_en    = 1'b0;
    logic [31:0] mem_data_out;
    logic        mem_excpt;
    logic        init_busy;
    logic        err_valid;
    logic [29:0] err_addr;
`ifdef MMIO_CONSOLE_EN
    logic        console_valid;
    logic [7:0]  console_char;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_mem [WORDS];
    int          m_busy = WORDS;
    logic        m_errv = 1'b0;
    logic [29:0] m_erra = '0;

    mips_data_mem #(
        .DATA_BASE    (BASE),
        .DATA_WORDS   (WORDS),
        .CONSOLE_ADDR (CONS)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_rd_en    (mem_rd_en),
        .mem_data_out (mem_data_out),
        .mem_excpt    (mem_excpt),
        .init_busy    (init_busy),
        .err_valid    (err_valid),
        .err_addr     (err_addr)
`ifdef MMIO_CONSOLE_EN
        ,
        .console_valid (console_valid),
        .console_char  (console_char)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [29:0] a);
        logic [31:0] ba;
        ba = {a, 2'b00};
        return (ba >= BASE) && (ba < BASE + 32'(4 * WORDS));
    endfunction

    function automatic int m_idx(input logic [29:0] a);
        logic [31:0] ba;
        ba = {a, 2'b00};
        return int'((ba - BASE) / 4);
    endfunction

    function automatic bit m_ok(input logic [29:0] a);
`ifdef MMIO_CONSOLE_EN
        return m_hit(a) || ({a, 2'b00} == CONS);
`else
        return m_hit(a);
`endif
    endfunction

    function automatic bit m_ready();
        return rst_b && (m_busy == 0);
    endfunction

    function automatic bit m_excpt();
        return m_ready() && !m_ok(mem_addr) &&
               (mem_rd_en || (mem_write_en != 4'h0));
    endfunction

    function automatic logic [31:0] m_rdata();
        if (m_ready() && m_hit(mem_addr)) begin
            return m_mem[m_idx(mem_addr)];
        end
        return 32'h0;
    endfunction

    // reference model state update
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_busy <= WORDS;
            m_errv <= 1'b0;
            m_erra <= '0;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                foreach (m_mem[i]) m_mem[i] <= 32'h0;
            end
        end else begin
            if (m_excpt() && !m_errv) begin
                m_errv <= 1'b1;
                m_erra <= mem_addr;
            end
            if (m_hit(mem_addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_write_en[b]) begin
                        m_mem[m_idx(mem_addr)][8*b +: 8] <=
                            mem_data_in[8*b +: 8];
                    end
                end
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", 32'(init_busy), 32'(m_busy != 0));
        chk("rdata", mem_data_out, m_rdata());
        chk("excpt", 32'(mem_excpt), 32'(m_excpt()));
        chk("errv", 32'(err_valid), 32'(m_errv));
        chk("erra", 32'(err_addr), 32'(m_erra));
    end

    task automatic drive(input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] we, input logic rd);
        @(posedge clk);
        #2;
        mem_addr     = a;
        mem_data_in  = d;
        mem_write_en = we;
        mem_rd_en    = rd;
    endtask

    task automatic idle();
        drive(30'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic set_rst(input logic v);
        @(posedge clk);
        #2;
        rst_b = v;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!init_busy) break;
            n++;
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < WORDS; i++) begin
            drive(BW + 30'(i), 32'h0, 4'h0, 1'b1);
        end
        idle();
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(init_busy), 32'h1);
        chk("rst_errv", 32'(err_valid), 32'h0);
        chk("rst_erra", 32'(err_addr), 32'h0);
        chk("rst_data", mem_data_out, 32'h0);
`ifdef MMIO_CONSOLE_EN
        chk("rst_cv", 32'(console_valid), 32'h0);
        chk("rst_cc", 32'(console_char), 32'h0);
`endif
        set_rst(1'b1);
        count_busy(n);
        chk("scrub_len", 32'(n), 32'd16);
        read_all();

        drive(BW + 30'd2, 32'hAABB_CCDD, 4'b1111, 1'b0);
        drive(BW + 30'd2, 32'h1122_3344, 4'b0101, 1'b0);
        drive(BW + 30'd2, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("lanes", mem_data_out, 32'hAA22_CC44);

        drive(BW + 30'd1, 32'h5, 4'b1111, 1'b1);
        @(negedge clk);
        chk("rdw_old", mem_data_out, 32'h0);
        drive(BW + 30'd1, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("rdw_new", mem_data_out, 32'h5);

        drive(BW + 30'd15, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("top_excpt", 32'(mem_excpt), 32'h0);
        drive(30'h03FF_FFFF, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("low_excpt", 32'(mem_excpt), 32'h1);
        chk("low_data", mem_data_out, 32'h0);
        drive(BW + 30'd16, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        @(negedge clk);
        chk("high_excpt", 32'(mem_excpt), 32'h1);
        idle();
        @(negedge clk);
        chk("err_v", 32'(err_valid), 32'h1);
        chk("err_a", 32'(err_addr), 32'h03FF_FFFF);
        drive(BW, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("oob_nowrite", mem_data_out, 32'h0);

`ifdef MMIO_CONSOLE_EN
        drive(CW, 32'h41, 4'b0001, 1'b0);
        drive(CW, 32'h41, 4'b0001, 1'b0);
        @(negedge clk);
        chk("con_excpt", 32'(mem_excpt), 32'h0);
        chk("con_v1", 32'(console_valid), 32'h1);
        chk("con_c1", 32'(console_char), 32'h41);
        idle();
        @(negedge clk);
        chk("con_v2", 32'(console_valid), 32'h1);
        chk("con_c2", 32'(console_char), 32'h41);
        @(negedge clk);
        chk("con_v3", 32'(console_valid), 32'h0);
        drive(CW, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("con_rd", mem_data_out, 32'h0);
        chk("con_rdx", 32'(mem_excpt), 32'h0);
        drive(CW, 32'h4200, 4'b0010, 1'b0);
        idle();
        @(negedge clk);
        chk("con_nolane", 32'(console_valid), 32'h0);
`else
        drive(CW, 32'h41, 4'b0001, 1'b0);
        @(negedge clk);
        chk("con_excpt", 32'(mem_excpt), 32'h1);
        idle();
`endif
        @(negedge clk);
        chk("err_keep", 32'(err_addr), 32'h03FF_FFFF);

        set_rst(1'b0);
        set_rst(1'b1);
        drive(BW + 30'd3, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        idle();
        repeat (4) @(posedge clk);
        set_rst(1'b0);
        @(negedge clk);
        chk("mid_busy", 32'(init_busy), 32'h1);
        chk("mid_errv", 32'(err_valid), 32'h0);
        set_rst(1'b1);
        count_busy(n);
        chk("rescrub_len", 32'(n), 32'd16);
        read_all();
        drive(BW + 30'd2, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("scrub_w2", mem_data_out, 32'h0);
        drive(BW + 30'd3, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("scrub_w3", mem_data_out, 32'h0);
        idle();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
